// File: rtl/mips32_dbg_loader.sv
// Host debug/loader port for the pipe_MIPS32 core: word WRITE/READ into the shared memory port
// and RUN (release core from PC=0, wait for HALTED, report cycle count), one response per command.
module mips32_dbg_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic [2:0]        dbg_state
);

  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam logic [1:0]  OP_RUN   = 2'b10;
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] CNT_TO   = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_RD_ADDR   = 3'd2,
    S_RD_WAIT   = 3'd3,
    S_RUN_START = 3'd4,
    S_RUN_WAIT  = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic [31:0]       count;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              addr_ok;
  logic              mem_op;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its
  // payload stable until then, and ready never depends on valid.
  assign accept  = cmd_valid && cmd_ready;
  assign addr_ok = 32'(cmd_addr) < MEM_DEPTH;
  assign mem_op  = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: state_nxt = addr_ok ? S_WRITE : S_RESP;
            OP_READ:  state_nxt = addr_ok ? S_RD_ADDR : S_RESP;
            OP_RUN:   state_nxt = S_RUN_START;
            default:  state_nxt = S_RESP;
          endcase
        end
      end
      S_WRITE:     state_nxt = S_RESP;
      S_RD_ADDR:   state_nxt = S_RD_WAIT;
      S_RD_WAIT:   state_nxt = S_RESP;
      S_RUN_START: state_nxt = S_RUN_WAIT;
      S_RUN_WAIT:  if (cpu_halted || (count == CNT_LAST)) state_nxt = S_RESP;
      S_RESP:      if (rsp_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      count    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Only legal memory commands move the address/data registers, so mem_addr
            // stays put across RUN and rejected commands.
            if (mem_op && addr_ok) begin
              addr_q <= cmd_addr;
              if (cmd_op == OP_WRITE) wdata_q <= cmd_data;
            end
            if (!(mem_op && addr_ok) && (cmd_op != OP_RUN)) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          rsp_data <= wdata_q;
          rsp_err  <= 1'b0;
        end
        S_RD_WAIT: begin
          rsp_data <= mem_rdata;
          rsp_err  <= 1'b0;
        end
        S_RUN_START: count <= '0;
        S_RUN_WAIT: begin
          if (cpu_halted) begin
            rsp_data <= count;
            rsp_err  <= 1'b0;
          end else if (count == CNT_LAST) begin
            rsp_data <= CNT_TO;
            rsp_err  <= 1'b1;
          end else begin
            count <= count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // cpu_halted is only looked at in RUN_WAIT, so a HALTED left over from the last run is ignored.
  assign cmd_ready = armed && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_start = (state == S_RUN_START);
  assign cpu_hold  = !((state == S_RUN_START) || (state == S_RUN_WAIT));
  assign dbg_state = state;

endmodule
